// File: rtl/dbus_mem_io.sv
// dbus_mem_io: data-side RAM and memory-mapped I/O target for the core's data port.
// DADDR[31]=0 selects a byte-enabled word RAM, DADDR[31]=1 an I/O page with LED,
// UART transmitter (8N1) and a free-running timer. Load data is registered.
// Optional: define DBUS_TIMER_EN to build the 32-bit timer at I/O offset 0x8;
// without it no timer flops exist and 0x8 reads 0.

module dbus_mem_io #(
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned UART_DIV   = 868,
    parameter int unsigned LED_W      = 8
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic [31:0]      DADDR,
    input  logic [31:0]      DATAO,
    input  logic [3:0]       BE,
    input  logic             WR,
    input  logic             RD,
    output logic [31:0]      DATAI,
    output logic [LED_W-1:0] LED,
    output logic             TXD,
    output logic             UART_BUSY
);

    localparam int unsigned Words   = 1 << MEM_ADDR_W;
    localparam logic [15:0] BaudMax = 16'(UART_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

    logic [31:0]           mem [Words];
    logic                  io_sel;
    logic [MEM_ADDR_W-1:0] widx;
    logic [1:0]            ridx;
    logic [31:0]           be_mask;
    logic                  ram_we, led_we, tx_wr, tx_accept, stat_rd;
    logic [31:0]           rdata, led_ext, timer_val;

    logic [31:0]      datai_q;
    logic [LED_W-1:0] led_q;
    logic             ovr_q;
    uart_st_e         state_q;
    logic [15:0]      baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             txd_q, busy_q;

    // Upper RAM address bits alias and byte offset bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{DADDR[30:MEM_ADDR_W+2], DADDR[1:0]};

    assign io_sel    = DADDR[31];
    assign widx      = DADDR[MEM_ADDR_W+1:2];
    assign ridx      = DADDR[3:2];
    assign be_mask   = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
    assign ram_we    = WR && !io_sel;
    assign led_we    = WR && io_sel && (ridx == 2'd0);
    assign tx_wr     = WR && io_sel && (ridx == 2'd1) && BE[0];
    assign tx_accept = tx_wr && (state_q == StIdle);
    assign stat_rd   = RD && io_sel && (ridx == 2'd1);

`ifdef DBUS_TIMER_EN
    logic [31:0] timer_q;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge CLK) begin
        if (!RES) timer_q <= '0;
        else      timer_q <= timer_q + 32'd1;
    end

    assign timer_val = timer_q;
`else
    assign timer_val = '0;
`endif

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && BE[i]) mem[widx][8*i +: 8] <= DATAO[8*i +: 8];
        end
    end

    // Read mux: RAM word or I/O register selected by DADDR[3:2].
    always_comb begin
        led_ext            = '0;
        led_ext[LED_W-1:0] = led_q;
        rdata              = '0;
        if (!io_sel) begin
            rdata = mem[widx];
        end else begin
            case (ridx)
                2'd0:    rdata = led_ext;
                2'd1:    rdata = {30'd0, ovr_q, busy_q};
                2'd2:    rdata = timer_val;
                default: rdata = '0;
            endcase
        end
    end

    // Registered load data; captures pre-write RAM contents on WR+RD.
    always_ff @(posedge CLK) begin
        if (!RES)    datai_q <= '0;
        else if (RD) datai_q <= rdata;
    end

    // LED register, written lane-wise under the byte enables.
    always_ff @(posedge CLK) begin
        if (!RES) led_q <= '0;
        else if (led_we) begin
            led_q <= (led_q & ~be_mask[LED_W-1:0]) | (DATAO[LED_W-1:0] & be_mask[LED_W-1:0]);
        end
    end

    // Overrun flag: a dropped TX byte sets it (wins over a same-edge status read clear).
    always_ff @(posedge CLK) begin
        if (!RES)                     ovr_q <= 1'b0;
        else if (tx_wr && !tx_accept) ovr_q <= 1'b1;
        else if (stat_rd)             ovr_q <= 1'b0;
    end

    // UART 8N1 transmitter, LSB first; TXD and busy are registered.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (tx_accept) begin
                        sh_q    <= DATAO[7:0];
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_q == BaudMax) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StData: begin
                    if (baud_q == BaudMax) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StStop: begin
                    if (baud_q == BaudMax) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign DATAI     = datai_q;
    assign LED       = led_q;
    assign TXD       = txd_q;
    assign UART_BUSY = busy_q;

endmodule

// File: tb/tb_dbus_mem_io.sv
// Directed bench for dbus_mem_io with UART_DIV=4.
module tb_dbus_mem_io;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] datao = '0;
    logic [3:0]  be = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] datai;
    logic [7:0]  led;
    logic        txd;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    dbus_mem_io #(
        .MEM_ADDR_W(10),
        .UART_DIV  (4),
        .LED_W     (8)
    ) dut (
        .CLK      (clk),
        .RES      (res),
        .DADDR    (daddr),
        .DATAO    (datao),
        .BE       (be),
        .WR       (wr),
        .RD       (rd),
        .DATAI    (datai),
        .LED      (led),
        .TXD      (txd),
        .UART_BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        daddr = a; datao = d; be = b; wr = 1'b1;
        tick();
        wr = 1'b0; be = '0;
    endtask

    // Two-cycle load; value taken in the DACK cycle (after the first edge).
    task automatic load(input logic [31:0] a, output logic [31:0] d);
        daddr = a; rd = 1'b1;
        tick();
        d = datai;
        tick();
        rd = 1'b0;
    endtask

    // Called just after the accepting edge; checks all 40 frame cycles.
    task automatic frame_check(input string tag, input logic [7:0] b);
        logic [9:0] fr;
        int         busy_cnt;
        fr = {1'b1, b, 1'b0};
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            check($sformatf("%s_txd%0d", tag, k), txd, fr[k/4]);
            if (busy) busy_cnt++;
            tick();
        end
        check({tag, "_busycnt"}, busy_cnt, 40);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_txd_end"}, txd, 1);
    endtask

    initial begin
        logic [31:0] d;

        // Reset state
        res = 1'b0;
        tick();
        check("rst_datai", datai, 0);
        check("rst_led", led, 0);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        res = 1'b1;
        tick();

        // RAM byte write
        store(32'h0000_0100, 32'hAABB_CCDD, 4'b1111);
        store(32'h0000_0100, 32'h0000_0011, 4'b0001);
        load(32'h0000_0100, d);
        check("ram_be", d, 32'hAABB_CC11);
        store(32'h0000_0100, 32'h7700_0000, 4'b1000);
        load(32'h0000_0100, d);
        check("ram_be3", d, 32'h77BB_CC11);

        // Alias and WR+RD overlap
        store(32'h0000_000C, 32'h1234_5678, 4'b1111);
        load(32'h0000_100C, d);
        check("ram_alias", d, 32'h1234_5678);
        daddr = 32'h0000_000C; datao = 32'hCAFE_F00D; be = 4'b1111; wr = 1'b1; rd = 1'b1;
        tick();
        check("wr_rd_old", datai, 32'h1234_5678);
        wr = 1'b0; be = '0;
        tick();
        rd = 1'b0;
        load(32'h0000_000C, d);
        check("wr_rd_new", d, 32'hCAFE_F00D);

        // LED
        store(32'h8000_0000, 32'h0000_005A, 4'b0001);
        check("led_wr", led, 8'h5A);
        store(32'h8000_0000, 32'h0000_00FF, 4'b1110);
        check("led_be_off", led, 8'h5A);
        load(32'h8000_0000, d);
        check("led_rd", d, 32'h0000_005A);
        load(32'h8000_000C, d);
        check("io_c_rd", d, 0);
        res = 1'b0;
        tick();
        check("led_rst", led, 0);
        res = 1'b1;
        tick();

        // UART frame 0xA5
        store(32'h8000_0004, 32'h0000_00A5, 4'b0001);
        frame_check("uartA5", 8'hA5);

        // Overrun: second write dropped, status read-clear
        store(32'h8000_0004, 32'h0000_00A5, 4'b0001);
        store(32'h8000_0004, 32'h0000_003C, 4'b0001);
        load(32'h8000_0004, d);
        check("stat_ovr", d, 32'h3);
        load(32'h8000_0004, d);
        check("stat_clr", d, 32'h1);
        for (int i = 0; i < 100 && busy; i++) tick();
        check("ovr_busy_done", busy, 0);
        load(32'h8000_0004, d);
        check("stat_idle", d, 32'h0);

        // Reset mid-frame (during data bit 3), then a full new frame
        store(32'h8000_0004, 32'h0000_005A, 4'b0001);
        for (int i = 0; i < 17; i++) tick();
        check("mid_bit3", txd, 1);
        check("mid_busy", busy, 1);
        res = 1'b0;
        tick();
        check("mid_rst_txd", txd, 1);
        check("mid_rst_busy", busy, 0);
        res = 1'b1;
        tick();
        store(32'h8000_0004, 32'h0000_003C, 4'b0001);
        frame_check("uart3C", 8'h3C);

        // Timer: RD sampled at the 11th edge after the last reset edge
        res = 1'b0;
        tick();
        res = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        daddr = 32'h8000_0008; rd = 1'b1;
        tick();
        rd = 1'b0;
`ifdef DBUS_TIMER_EN
        check("timer", datai, 32'd10);
`else
        check("timer", datai, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
